// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access controller: FSM state codes,
// error-cause codes and the helper that classifies an illegal access request.
package mem_access_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNALIGNED = 2'd1;
    localparam logic [1:0] ERR_RDWR      = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd3;

    // Only used for a live access; the caller gates it with validM and the sticky error.
    function automatic logic [1:0] idle_err_cause(input logic rd, input logic wr, input logic addr_lsb);
        if (rd && wr)
            return ERR_RDWR;
        else if (addr_lsb)
            return ERR_UNALIGNED;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and memory-side signals of the memory-stage controller; the
// controller is the master of the memory request bus.
interface mem_access_ctrl_if #(
    parameter int DW = 16
);
    logic          validM;
    logic          memRd;
    logic          memWr;
    logic [DW-1:0] addrIn;
    logic [DW-1:0] wrDataIn;
    logic          memBusy;
    logic          memDone;
    logic [DW-1:0] memRdData;
    logic          memReq;
    logic          memWe;
    logic [DW-1:0] memAddr;
    logic [DW-1:0] memWrData;
    logic [DW-1:0] readData;
    logic          stallM;
    logic          err;

    modport master (
        input  validM, memRd, memWr, addrIn, wrDataIn, memBusy, memDone, memRdData,
        output memReq, memWe, memAddr, memWrData, readData, stallM, err
    );

    modport slave (
        output validM, memRd, memWr, addrIn, wrDataIn, memBusy, memDone, memRdData,
        input  memReq, memWe, memAddr, memWrData, readData, stallM, err
    );
endinterface

// File: rtl/mem_tmo_cnt.sv
// Saturating watchdog counter for the WAIT state; tc flags that the last
// permitted wait cycle (TMO_CYC-1) has been reached.
module mem_tmo_cnt #(
    parameter int TMO_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int CW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] TERM = CW'(TMO_CYC - 1);

    logic [CW-1:0] count;

    // Holds at the terminal value so a missed abort can never wrap back to zero.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && !tc)
            count <= count + CW'(1);
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns a latched load/store into a single
// req/done transaction on a multi-cycle memory and stalls the pipe meanwhile.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DW      = 16,
    parameter int TMO_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.master bus
);
    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [1:0]    err_cause;
    logic          latch_req;
    logic          cnt_clr;
    logic          cnt_en;
    logic          load_rd;
    logic          tmo;
    logic          access;
    logic          err_q;
    logic          we_q;
    logic [DW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;

    assign access = bus.validM & (bus.memRd | bus.memWr) & ~err_q;

    mem_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tmo)
    );

    always_comb begin
        state_next = state;
        err_cause  = ERR_NONE;
        latch_req  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        load_rd    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    err_cause = idle_err_cause(bus.memRd, bus.memWr, bus.addrIn[0]);
                    if (err_cause == ERR_NONE) begin
                        latch_req  = 1'b1;
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.memBusy) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the final permitted cycle beats the timeout.
                if (bus.memDone) begin
                    load_rd    = ~we_q;
                    state_next = ST_RESP;
                end else if (tmo) begin
                    err_cause  = ERR_TIMEOUT;
                    state_next = ST_RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (err_cause != ERR_NONE)
                err_q <= 1'b1;
            if (latch_req) begin
                addr_q  <= bus.addrIn;
                wdata_q <= bus.wrDataIn;
                we_q    <= bus.memWr;
            end
            if (load_rd)
                rdata_q <= bus.memRdData;
        end
    end

    // The IDLE term lets the stall cover the very first cycle of a legal access.
    assign bus.stallM    = ((state == ST_IDLE) & latch_req) | (state == ST_ISSUE) | (state == ST_WAIT);
    assign bus.memReq    = (state == ST_ISSUE) & ~bus.memBusy;
    assign bus.memWe     = bus.memReq & we_q;
    assign bus.memAddr   = addr_q;
    assign bus.memWrData = wdata_q;
    assign bus.readData  = rdata_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a transaction-level model predicts requests
// and retirements, a memory responder answers requests, a monitor checks outputs.
module tb_mem_access_ctrl;
    localparam int DW  = 16;
    localparam int TMO = 64;

    typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; } req_t;
    typedef struct { int stall; logic [15:0] rdata; logic err; } resp_t;
    typedef struct { int k; logic [15:0] data; } mem_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_access_ctrl_if #(.DW(DW)) bus ();

    mem_access_ctrl #(.DW(DW), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t  req_q[$];
    resp_t resp_q[$];
    mem_t  mem_q[$];

    int          n_checks   = 0;
    int          n_fail     = 0;
    bit          mon_en     = 1'b0;
    int          stall_cnt  = 0;
    bit          err_pend   = 1'b0;
    logic        err_expect = 1'b0;
    logic        m_err      = 1'b0;
    logic [15:0] m_rdata    = '0;
    req_t        mon_r;
    resp_t       mon_e;
    mem_t        rsp_m;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers each request k cycles later, k == 0 means never.
    initial begin
        bus.memDone   = 1'b0;
        bus.memRdData = '0;
        forever begin
            @(negedge clk);
            bus.memRdData = 16'($urandom);
            if (bus.memReq && mem_q.size() > 0) begin
                rsp_m = mem_q.pop_front();
                if (rsp_m.k > 0) begin
                    repeat (rsp_m.k) @(posedge clk);
                    #1;
                    bus.memDone   = 1'b1;
                    bus.memRdData = rsp_m.data;
                    @(posedge clk);
                    #1;
                    bus.memDone   = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (err_pend) begin
                checkOutput("err_after_retire", bus.err, err_expect);
                err_pend = 1'b0;
            end
            if (bus.memReq) begin
                if (req_q.size() == 0) begin
                    checkOutput("memReq_unexpected", bus.memReq, 0);
                end else begin
                    mon_r = req_q.pop_front();
                    checkOutput("memAddr", bus.memAddr, mon_r.addr);
                    checkOutput("memWe", bus.memWe, mon_r.we);
                    checkOutput("memWrData", bus.memWrData, mon_r.wdata);
                end
            end
            if (bus.validM) begin
                if (bus.stallM) begin
                    stall_cnt++;
                end else if (resp_q.size() == 0) begin
                    checkOutput("retire_unexpected_stallM", bus.stallM, 1);
                end else begin
                    mon_e = resp_q.pop_front();
                    checkOutput("stall_cycles", stall_cnt, mon_e.stall);
                    checkOutput("readData", bus.readData, mon_e.rdata);
                    err_expect = mon_e.err;
                    err_pend   = 1'b1;
                    stall_cnt  = 0;
                end
            end else begin
                checkOutput("bubble_stallM", bus.stallM, 0);
            end
        end
    end

    task automatic applyReset();
        mon_en       = 1'b0;
        rst          = 1'b1;
        bus.validM   = 1'b0;
        bus.memRd    = 1'b0;
        bus.memWr    = 1'b0;
        bus.addrIn   = '0;
        bus.wrDataIn = '0;
        bus.memBusy  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_stallM", bus.stallM, 0);
        checkOutput("rst_memReq", bus.memReq, 0);
        checkOutput("rst_memWe", bus.memWe, 0);
        checkOutput("rst_memAddr", bus.memAddr, 0);
        checkOutput("rst_memWrData", bus.memWrData, 0);
        checkOutput("rst_readData", bus.readData, 0);
        checkOutput("rst_err", bus.err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_q.delete();
        resp_q.delete();
        mem_q.delete();
        m_err     = 1'b0;
        m_rdata   = '0;
        stall_cnt = 0;
        err_pend  = 1'b0;
        mon_en    = 1'b1;
    endtask

    task automatic applyBubble();
        bus.validM   = 1'b0;
        bus.memRd    = 1'($urandom);
        bus.memWr    = 1'($urandom);
        bus.addrIn   = 16'($urandom);
        bus.wrDataIn = 16'($urandom);
        bus.memBusy  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Predicts the instruction's outcome, then holds it until the pipe advances.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                 input logic [15:0] wdata, input int busy, input int k,
                                 input logic [15:0] rdata);
        req_t  r;
        resp_t e;
        mem_t  m;
        int    cyc;
        bit    retired;
        e.stall = 0;
        if (!m_err && (rd || wr)) begin
            if (addr[0] || (rd && wr)) begin
                m_err = 1'b1;
            end else begin
                r = '{addr: addr, we: wr, wdata: wdata};
                req_q.push_back(r);
                m = '{k: k, data: rdata};
                mem_q.push_back(m);
                if (k >= 1 && k <= TMO) begin
                    e.stall = busy + k + 2;
                    if (rd) m_rdata = rdata;
                end else begin
                    e.stall = busy + TMO + 2;
                    m_err   = 1'b1;
                end
            end
        end
        e.rdata = m_rdata;
        e.err   = m_err;
        resp_q.push_back(e);

        bus.validM   = 1'b1;
        bus.memRd    = rd;
        bus.memWr    = wr;
        bus.addrIn   = addr;
        bus.wrDataIn = wdata;
        bus.memBusy  = (busy > 0);
        cyc     = 0;
        retired = 1'b0;
        while (!retired && cyc < busy + TMO + 20) begin
            @(negedge clk);
            if (!bus.stallM) retired = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            bus.memBusy = (cyc <= busy);
        end
        if (!retired) checkOutput("retire_bound_stallM", bus.stallM, 0);
        bus.memBusy = 1'b0;
    endtask

    task automatic phaseEnd();
        applyBubble();
        checkOutput("req_q_drained", req_q.size(), 0);
        checkOutput("resp_q_drained", resp_q.size(), 0);
        applyReset();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int kind;
        bit seen;
        applyReset();

        applyStimulus(1, 0, 16'h0010, 16'h0000, 0, 3, 16'hBEEF);
        applyStimulus(0, 1, 16'h0020, 16'h1234, 2, 2, 16'hC0DE);
        applyStimulus(1, 0, 16'h0002, 16'h0000, 0, 1, 16'hAAAA);
        applyStimulus(1, 0, 16'h0004, 16'h0000, 0, 2, 16'h5555);
        applyStimulus(1, 0, 16'h0006, 16'h0000, 1, TMO, 16'h0F0F);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) applyBubble();
            applyStimulus(kind < 2, kind == 2, 16'($urandom) & 16'hFFFE, 16'($urandom),
                          $urandom_range(0, 3), $urandom_range(1, 6), 16'($urandom));
        end
        phaseEnd();

        applyStimulus(1, 0, 16'h0011, 16'h0000, 0, 2, 16'h1111);
        applyStimulus(1, 0, 16'h0010, 16'h0000, 0, 2, 16'h2222);
        applyStimulus(0, 1, 16'h0010, 16'h3333, 0, 2, 16'h0000);
        phaseEnd();

        applyBubble();
        applyStimulus(1, 1, 16'h0008, 16'h4444, 0, 2, 16'h5151);
        phaseEnd();

        applyStimulus(1, 0, 16'h0030, 16'h0000, 1, 0, 16'h6666);
        applyStimulus(1, 0, 16'h0032, 16'h0000, 0, 2, 16'h7070);
        phaseEnd();

        applyStimulus(1, 0, 16'h0034, 16'h0000, 0, TMO + 1, 16'hDEAD);
        phaseEnd();

        mon_en       = 1'b0;
        bus.validM   = 1'b1;
        bus.memRd    = 1'b1;
        bus.memWr    = 1'b0;
        bus.addrIn   = 16'h0040;
        bus.wrDataIn = 16'h0000;
        mem_q.push_back('{k: 2, data: 16'h7777});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.memReq;
        end
        checkOutput("rstwait_memReq_seen", seen, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rstwait_stall_in_wait", bus.stallM, 1);
        rst        = 1'b1;
        bus.validM = 1'b0;
        bus.memRd  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rstwait_stallM", bus.stallM, 0);
            checkOutput("rstwait_memReq", bus.memReq, 0);
            checkOutput("rstwait_readData", bus.readData, 0);
            checkOutput("rstwait_err", bus.err, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
